lsu: RTL

Multi-cycle load/store unit that acts as the initiator toward the data memory. It sits between the execute stage and a variable-latency data memory. For each memory instruction it issues one request/acknowledge transaction with byte enables, then returns aligned and extended load data to the register write-back path. Non-memory instructions pass the ALU result through unchanged, and the unit stalls the core while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_if.sv | 20 ++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

    // MIPS I load/store opcodes (Ins[31:26]).
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2b;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: is_mem_op = 1'b1;
            default:                                          is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables / store replication / misalign check on the
// way out, lane select and sign/zero extension of load data on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [5:0]  i_st_op,
    input  logic [1:0]  i_st_adr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    input  logic [5:0]  i_ld_op,
    input  logic [1:0]  i_ld_adr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Enables and replicated store data from access size and low address bits.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_st_op)
            OpLw, OpSw: begin
                o_be       = 4'b1111;
                o_misalign = (i_st_adr != 2'b00);
            end
            OpLh, OpLhu, OpSh: begin
                o_be       = i_st_adr[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_st_adr[0];
            end
            OpLb, OpLbu, OpSb: begin
                o_be    = 4'b0001 << i_st_adr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane and extend it; stores and non-memory ops yield zero.
    always_comb begin
        w_byte    = i_rdata[{i_ld_adr, 3'b000} +: 8];
        w_half    = i_ld_adr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ld_data = 32'h0;
        case (i_ld_op)
            OpLb:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            OpLbu:   o_ld_data = {24'h0, w_byte};
            OpLh:    o_ld_data = {{16{w_half[15]}}, w_half};
            OpLhu:   o_ld_data = {16'h0, w_half};
            OpLw:    o_ld_data = i_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory transaction per accepted instruction, with timeout,
// misalign trapping and pass-through of non-memory results.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] Ins,
    input  logic [31:0] Adr,
    input  logic [31:0] Wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] Rdata,
    output logic        err,
    lsu_if.master       mem
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_op;
    logic [1:0]        r_adr_lo;
    logic [31:0]       r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [5:0]        w_op;
    logic              w_is_mem;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misalign;
    logic [31:0]       w_ld_data;
    logic              w_timeout;
    logic              w_unused_ins;

    assign w_op         = Ins[31:26];
    assign w_is_mem     = is_mem_op(w_op);
    assign w_unused_ins = ^Ins[25:0];
    // Last permitted request cycle: the counter starts at 0 on entry to REQ.
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    lsu_align u_align (
        .i_st_op    (w_op),
        .i_st_adr   (Adr[1:0]),
        .i_wdata    (Wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign),
        .i_ld_op    (r_op),
        .i_ld_adr   (r_adr_lo),
        .i_rdata    (mem.mem_rdata),
        .o_ld_data  (w_ld_data)
    );

    // State register; async reset drops mem_req immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: non-memory and misaligned ops skip REQ entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (w_is_mem && !w_misalign) ? StReq : StResp;
                end
            end
            StReq: begin
                if (mem.mem_ack || w_timeout) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        busy        = (r_state != StIdle);
        done        = (r_state == StResp);
        mem.mem_req = (r_state == StReq);
    end

    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
    assign Rdata         = r_rdata;
    assign err           = r_err;

    // Latch the request on accept; in REQ capture the result, flag timeout, or count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt    <= '0;
            r_op     <= 6'h0;
            r_adr_lo <= 2'b00;
            r_addr   <= 32'h0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_we     <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        if (!w_is_mem) begin
                            r_rdata <= Adr;
                            r_err   <= 1'b0;
                        end else if (w_misalign) begin
                            r_rdata <= 32'h0;
                            r_err   <= 1'b1;
                        end else begin
                            r_op     <= w_op;
                            r_adr_lo <= Adr[1:0];
                            r_addr   <= {Adr[31:2], 2'b00};
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                            r_we     <= is_store(w_op);
                            r_cnt    <= '0;
                        end
                    end
                end
                StReq: begin
                    if (mem.mem_ack) begin
                        r_rdata <= r_we ? 32'h0 : w_ld_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
